output_accumulator: RTL and testbench

Parametrised successor to the single-lane output stage of the systolic array.
- Takes the N_COLS_ARRAY column partial sums.
- Routes any column, or zero, to each of N_LANES accumulation lanes.
- Accumulates per-lane into DEPTH-entry internal memories with a forwarded read-modify-write pipeline.
- Under an FSM, streams accumulated results out over a valid/ready interface, clearing each entry as it is read.

---
 rtl/output_acc_pkg.sv | 51 +++++
 rtl/acc_lane.sv | 68 ++++++
 rtl/output_accumulator.sv | 159 +++++++++++++++
 tb/tb_output_accumulator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_acc_pkg.sv
// Shared types, widths and saturating adder for the output accumulator.
// Define OUTPUT_ACC_SATURATE_EN to clamp overflowing sums instead of wrapping.
package output_acc_pkg;

    localparam int I_WIDTH_DEF = 8;
    localparam int F_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic        ovf;
        logic [63:0] sum;
    } add_res_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands arrive sign-extended; the low dw bits of .sum are the result.
    function automatic add_res_t sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 dw
    );
        add_res_t           res;
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s       = a + b;
        mx      = (64'sd1 <<< (dw - 1)) - 64'sd1;
        mn      = -(64'sd1 <<< (dw - 1));
        res.ovf = (s > mx) || (s < mn);
`ifdef OUTPUT_ACC_SATURATE_EN
        if (s > mx) begin
            res.sum = mx;
        end else if (s < mn) begin
            res.sum = mn;
        end else begin
            res.sum = s;
        end
`else
        res.sum = s;
`endif
        return res;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulation lane: DEPTH-entry memory behind a two-stage
// read-modify-write pipeline with write-to-read forwarding.
module acc_lane
    import output_acc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_en,
    input  logic                 first,
    input  logic [AW-1:0]        addr,
    input  logic signed [DW-1:0] operand,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic [AW-1:0]        peek_addr,
    output logic signed [DW-1:0] peek_data,
    output logic                 busy,
    output logic                 ovf
);

    logic signed [DW-1:0] mem [DEPTH];
    logic                 s2_valid;
    logic                 s2_first;
    logic [AW-1:0]        s2_addr;
    logic signed [DW-1:0] s2_op;
    logic signed [DW-1:0] rd_q;
    logic signed [DW-1:0] sum;
    add_res_t             res;
    logic                 unused_hi;

    always_comb begin
        res = sat_add(s2_first ? 64'sd0 : 64'(rd_q), 64'(s2_op), DW);
        sum = res.sum[DW-1:0];
    end

    assign unused_hi = ^res.sum[63:DW];

    // A read that collides with the write of the same edge takes the new sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= in_en;
        end
        if (in_en) begin
            s2_addr  <= addr;
            s2_first <= first;
            s2_op    <= operand;
            rd_q     <= (s2_valid && s2_addr == addr) ? sum : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (s2_valid) begin
            mem[s2_addr] <= sum;
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end
    end

    assign peek_data = mem[peek_addr];
    assign busy      = s2_valid;
    assign ovf       = s2_valid && res.ovf;

endmodule

// File: rtl/output_accumulator.sv
// Multi-lane output accumulator with flush/drain streaming FSM.
// Overflow behaviour follows OUTPUT_ACC_SATURATE_EN (clamp) or wraps.
module output_accumulator
    import output_acc_pkg::*;
#(
    parameter int  N_COLS_ARRAY = 3,
    parameter int  I_WIDTH      = I_WIDTH_DEF,
    parameter int  F_WIDTH      = F_WIDTH_DEF,
    parameter int  N_LANES      = 2,
    parameter int  DEPTH        = 4,
    localparam int DW           = I_WIDTH + F_WIDTH,
    localparam int ADDR_WIDTH   = idx_width(DEPTH),
    localparam int SEL_WIDTH    = $clog2(N_COLS_ARRAY + 1),
    localparam int LANE_WIDTH   = idx_width(N_LANES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic signed [DW-1:0]  data_in_i [N_COLS_ARRAY],
    input  logic [SEL_WIDTH-1:0]  col_sel_i [N_LANES],
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  first_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  drain_i,
    output logic signed [DW-1:0]  out_data_o,
    output logic [LANE_WIDTH-1:0] out_lane_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic                  hs;
    logic                  is_last;
    logic                  pipe_busy;
    logic [N_LANES-1:0]    lane_busy;
    logic [N_LANES-1:0]    lane_ovf;
    logic signed [DW-1:0]  operand [N_LANES];
    logic signed [DW-1:0]  peek [N_LANES];
    logic signed [DW-1:0]  peek_sel;
    logic [LANE_WIDTH-1:0] nxt_lane;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [LANE_WIDTH-1:0] load_lane;
    logic [ADDR_WIDTH-1:0] load_addr;

    assign in_ready_o = (state == RUN);
    assign accept     = in_valid_i && in_ready_o;
    assign hs         = (state == DRAIN) && out_valid_o && out_ready_i;
    assign pipe_busy  = |lane_busy;
    assign busy_o     = (state != RUN) || pipe_busy;
    assign is_last    = (out_lane_o == LANE_WIDTH'(N_LANES - 1))
                     && (out_addr_o == ADDR_WIDTH'(DEPTH - 1));
    assign out_last_o = out_valid_o && is_last;

    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            operand[l] = '0;
            for (int c = 0; c < N_COLS_ARRAY; c++) begin
                if (col_sel_i[l] == SEL_WIDTH'(c + 1)) begin
                    operand[l] = data_in_i[c];
                end
            end
        end
    end

    // Drain order is addr-major, lane-minor.
    always_comb begin
        if (out_lane_o == LANE_WIDTH'(N_LANES - 1)) begin
            nxt_lane = '0;
            nxt_addr = out_addr_o + ADDR_WIDTH'(1);
        end else begin
            nxt_lane = out_lane_o + LANE_WIDTH'(1);
            nxt_addr = out_addr_o;
        end
        load_lane = (state == FLUSH) ? '0 : nxt_lane;
        load_addr = (state == FLUSH) ? '0 : nxt_addr;
        peek_sel  = '0;
        for (int l = 0; l < N_LANES; l++) begin
            if (load_lane == LANE_WIDTH'(l)) begin
                peek_sel = peek[l];
            end
        end
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        acc_lane #(
            .DW   (DW),
            .DEPTH(DEPTH),
            .AW   (ADDR_WIDTH)
        ) u_lane (
            .clk      (clk_i),
            .rst      (rst_i),
            .in_en    (accept),
            .first    (first_i),
            .addr     (addr_i),
            .operand  (operand[l]),
            .clr_en   (hs && out_lane_o == LANE_WIDTH'(l)),
            .clr_addr (out_addr_o),
            .peek_addr(load_addr),
            .peek_data(peek[l]),
            .busy     (lane_busy[l]),
            .ovf      (lane_ovf[l])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RUN:     if (drain_i) next_state = FLUSH;
            FLUSH:   if (!pipe_busy) next_state = DRAIN;
            DRAIN:   if (hs && is_last) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_lane_o  <= '0;
            out_addr_o  <= '0;
        end else if (state == FLUSH && !pipe_busy) begin
            out_valid_o <= 1'b1;
            out_data_o  <= peek_sel;
            out_lane_o  <= '0;
            out_addr_o  <= '0;
        end else if (hs) begin
            if (is_last) begin
                out_valid_o <= 1'b0;
            end else begin
                out_data_o <= peek_sel;
                out_lane_o <= nxt_lane;
                out_addr_o <= nxt_addr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
        end else if (|lane_ovf) begin
            ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_accumulator.sv
// Directed bench for output_accumulator with an entry-level reference model.
// Build with or without OUTPUT_ACC_SATURATE_EN to match the RTL.
module tb_output_accumulator;

    localparam int NL   = 2;
    localparam int ND   = 4;
    localparam int NB   = NL * ND;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;
`ifdef OUTPUT_ACC_SATURATE_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = -32768;
`endif

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic signed [15:0] din [3];
    logic [1:0]         sel [NL];
    logic [1:0]         addr;
    logic               first;
    logic               in_valid;
    logic               in_ready;
    logic               drain;
    logic signed [15:0] out_data;
    logic [0:0]         out_lane;
    logic [1:0]         out_addr;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               ovf;

    int total = 0;
    int bad   = 0;
    int m [NL][ND];
    int drained [NL][ND];
    int exp_idx = 0;
    bit m_ovf = 1'b0;

    always #5 clk = ~clk;

    output_accumulator dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_in_i  (din),
        .col_sel_i  (sel),
        .addr_i     (addr),
        .first_i    (first),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .drain_i    (drain),
        .out_data_o (out_data),
        .out_lane_o (out_lane),
        .out_addr_o (out_addr),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_last_o (out_last),
        .busy_o     (busy),
        .ovf_o      (ovf)
    );

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int acc(input int a, input int b, output bit ov);
        int s;
        s  = a + b;
        ov = (s > MAXV) || (s < MINV);
`ifdef OUTPUT_ACC_SATURATE_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`else
        if (s > MAXV) s -= 65536;
        if (s < MINV) s += 65536;
`endif
        return s;
    endfunction

    // Reference model: entries update on accept, clear on drain handshake.
    always @(negedge clk) begin : cmp
        int el;
        int ea;
        int op;
        bit ov;
        if (rst_i) begin
            exp_idx = 0;
            m_ovf   = 1'b0;
        end else begin
            if (!busy) chk("ovf_model", int'(ovf), int'(m_ovf));
            if (in_valid && in_ready) begin
                for (int l = 0; l < NL; l++) begin
                    op = 0;
                    if (sel[l] != 0) op = int'(din[int'(sel[l]) - 1]);
                    if (first) begin
                        m[l][addr] = op;
                    end else begin
                        m[l][addr] = acc(m[l][addr], op, ov);
                        if (ov) m_ovf = 1'b1;
                    end
                end
            end
            if (out_valid) begin
                el = exp_idx % NL;
                ea = exp_idx / NL;
                chk("out_lane", int'(out_lane), el);
                chk("out_addr", int'(out_addr), ea);
                chk("out_data", int'(out_data), m[el][ea]);
                chk("out_last", int'(out_last), int'(exp_idx == NB - 1));
                if (out_ready) begin
                    drained[el][ea] = int'(out_data);
                    m[el][ea] = 0;
                    exp_idx = (exp_idx + 1) % NB;
                end
            end
        end
    end

    task automatic beat(input int a, input int s0, input int s1,
                        input int c0, input int c1, input int c2,
                        input bit f);
        @(posedge clk);
        #2;
        addr     = 2'(a);
        sel[0]   = 2'(s0);
        sel[1]   = 2'(s1);
        din[0]   = 16'(c0);
        din[1]   = 16'(c1);
        din[2]   = 16'(c2);
        first    = f;
        in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_drain();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        drain    = 1'b1;
        @(posedge clk);
        #2;
        drain = 1'b0;
    endtask

    task automatic finish_drain(input int stall_beat);
        int nbeat;
        int st;
        int hold_d;
        int hold_a;
        bit done;
        nbeat = 0;
        st    = 0;
        done  = 1'b0;
        hold_d = 0;
        hold_a = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                st++;
                if (st == 1) begin
                    hold_d = int'(out_data);
                    hold_a = int'(out_addr);
                end else begin
                    chk("stall_data", int'(out_data), hold_d);
                    chk("stall_addr", int'(out_addr), hold_a);
                end
            end
            if (out_valid && out_ready) begin
                if (out_last) begin
                    chk("last_lane", int'(out_lane), 1);
                    chk("last_addr", int'(out_addr), 3);
                    done = 1'b1;
                end
                nbeat++;
            end
            @(posedge clk);
            #2;
            out_ready = !(nbeat == stall_beat && st < 3);
        end
        if (!done) chk("drain_timeout", 0, 1);
        chk("drain_beats", nbeat, NB);
        if (stall_beat >= 0) chk("stall_cycles", st, 3);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hs;
        foreach (m[l, a]) m[l][a] = 0;
        foreach (drained[l, a]) drained[l][a] = -1;
        for (int i = 0; i < 3; i++) din[i] = '0;
        for (int l = 0; l < NL; l++) sel[l] = '0;
        addr = '0;
        first = 1'b0;
        in_valid = 1'b0;
        drain = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);

        for (int a = 0; a < ND; a++) beat(a, 0, 0, 0, 0, 0, 1'b1);
        idle(3);

        // Back-to-back same address exercises forwarding.
        beat(2, 1, 0, 100, 0, 0, 1'b1);
        beat(2, 1, 0, 5, 0, 0, 1'b0);
        beat(2, 1, 0, -7, 0, 0, 1'b0);
        start_drain();
        finish_drain(-1);
        chk("fwd_l0_a2", drained[0][2], 98);
        chk("fwd_l1_a2", drained[1][2], 0);

        beat(1, 2, 0, 0, 32767, 0, 1'b1);
        beat(1, 2, 0, 0, 1, 0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("sat_ovf", int'(ovf), 1);
        start_drain();
        finish_drain(-1);
        chk("sat_value", drained[0][1], SAT_EXP);

        for (int a = 0; a < ND; a++) beat(a, 1, 2, 10 * a + 1, 10 * a + 2, 0, 1'b1);
        idle(2);
        start_drain();
        finish_drain(1);
        chk("fill_l0_a0", drained[0][0], 1);
        chk("fill_l1_a3", drained[1][3], 32);
        start_drain();
        finish_drain(-1);
        foreach (drained[l, a]) chk("cleared", drained[l][a], 0);

        // Beat accepted in the same cycle drain is requested.
        @(posedge clk);
        #2;
        addr = 2'd0;
        sel[0] = 2'd1;
        sel[1] = 2'd0;
        din[0] = 16'sd55;
        first = 1'b1;
        in_valid = 1'b1;
        drain = 1'b1;
        @(posedge clk);
        #2;
        drain = 1'b0;
        din[0] = 16'sd999;
        first = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready), 0);
        finish_drain(-1);
        in_valid = 1'b0;
        chk("same_cycle_beat", drained[0][0], 55);

        for (int a = 0; a < ND; a++) beat(a, 1, 2, 200 + a, 300 + a, 0, 1'b1);
        idle(2);
        start_drain();
        hs = 0;
        for (int c = 0; c < 40 && hs < 3; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
        end
        chk("pre_reset_beats", hs, 3);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstd_out_valid", int'(out_valid), 0);
        chk("rstd_in_ready", int'(in_ready), 1);
        chk("rstd_busy", int'(busy), 0);
        chk("rstd_ovf", int'(ovf), 0);
        start_drain();
        finish_drain(-1);
        chk("kept_l1_a1", drained[1][1], 301);
        chk("kept_l0_a3", drained[0][3], 203);
        chk("gone_l0_a0", drained[0][0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
